spi_prog_loader: RTL and testbench
==================================

# spi_prog_loader

- Serial programming front end that loads program images into the MRAM before the CPU runs.
- Sits between the SPI pads and the memory controller's programming port:
  - receives SPI mode-0 frames from an external host;
  - assembles 32-bit words;
  - emits one single-cycle write strobe per word, with address and data, while the chip is held in programming mode.
- Also returns a status response on `miso` so the host can check that its download arrived.

## Interface

Parameters:
- `ADDR_W`, default 16: width of `paddr`, a word address.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `sclk`, `mosi` and `ss`.

Ports:
- `clk` in, 1: system clock; the only clock in the block.
- `aresetbar` in, 1: reset, asynchronous and active-low.
- `PROGRAM` in, 1: programming-mode enable, already synchronized to `clk`, active-high.
- `sclk` in, 1: SPI clock, asynchronous; idles low.
- `mosi` in, 1: SPI data in, MSB first, asynchronous.
- `ss` in, 1: SPI select, active-low, asynchronous.
- `miso` out, 1: SPI data out, MSB first.
- `pwe_pulse_q` out, 1: one-cycle write strobe to the memory controller.
- `paddr` out, `ADDR_W`: word address qualified by `pwe_pulse_q`.
- `pdata` out, 32: write data qualified by `pwe_pulse_q`.
- `busy` out, 1: high while a frame is being decoded.

## Operation

- `sclk`, `mosi` and `ss` each pass through `SYNC_STAGES` flip-flops. Edge detection runs on the synchronized `sclk`.
- Sampling and shifting:
  - `mosi` is sampled on each detected `sclk` rise.
  - `miso` shifts on each detected `sclk` fall.
  - The first `miso` bit is valid from the detected `ss` fall.
- A frame runs from the `ss` fall to the `ss` rise. Byte 0 is the command.
- Command `0x02` (write burst):
  - Next 2 bytes give the start address, MSB first; its low `ADDR_W` bits are loaded into the address counter.
  - After that, each 4 bytes form one data word, big-endian.
  - Each completed word produces one `pwe_pulse_q`, with `paddr` equal to the counter. The counter then increments.
  - The counter wraps from all-ones to 0.
  - An unbounded number of words is allowed per frame.
- Command `0x05` (status): `miso` returns 2 bytes, then 0s.
  - Byte 0: `wcount[7:0]`, the number of words strobed since the last `0x02` command byte; it wraps at 256.
  - Byte 1: the CRC byte (see Configuration).
- Any other command: remaining bits are ignored until `ss` rises; no strobe is issued.
- FSM states and transitions:
  - IDLE → CMD on `ss` fall with `PROGRAM`=1.
  - CMD → ADDR (`0x02`), STAT (`0x05`), or IGNORE (anything else).
  - ADDR → DATA after 16 bits.
  - DATA → DATA after every 32 bits.
  - STAT → IGNORE after 16 bits.
  - Every state except IDLE → IDLE on `ss` rise.
- Boundary conditions:
  - `ss` rising mid-byte or mid-word discards the partial bits; no strobe is issued, and the counter and `wcount` are kept.
  - `ss` falling with `PROGRAM`=0 goes to IGNORE.
  - `PROGRAM` falling mid-frame forces IGNORE immediately; a word not yet strobed is dropped.
  - Fewer than 16 address bits before `ss` rises leaves the counter unchanged from its previous value.
  - `busy` = (state ≠ IDLE).

## Timing

- Reset values:
  - `pwe_pulse_q`=0, `paddr`=0, `pdata`=0, `miso`=0, `busy`=0;
  - state IDLE, `wcount`=0, CRC=0x00.
- The `sclk` high and low times must each be at least `SYNC_STAGES`+1 `clk` periods. Faster `sclk` is unsupported.
- `pwe_pulse_q` is high for exactly 1 `clk` cycle, in the cycle after the detected rise that samples bit 31 of a word.
- `paddr` and `pdata` update in the same cycle as the pulse and hold until the next pulse.
- Strobe spacing is at least 32 detected `sclk` periods, so no back-pressure is needed.
- The first word's address equals the start address. The counter increments in the cycle after the pulse.
- A simultaneous `ss` rise and last-bit rise counts as a completed word only if the rise was detected before the `ss` rise.
- `miso` holds 0 outside STAT.

## Configuration

- `SPI_PROG_CRC_EN` defined:
  - a CRC-8 (poly 0x07, init 0x00, MSB first) runs over every data byte of every strobed word, in stream order;
  - it is reset to 0x00 by each `0x02` command byte;
  - status byte 1 returns this CRC.
- Undefined: no CRC logic is built, and status byte 1 is 0x00.

## Test plan

- Reset, then write burst with start address 0x0010 and data 0xDEADBEEF, 0x00000013:
  - expect exactly two 1-cycle pulses, (0x0010, 0xDEADBEEF) then (0x0011, 0x00000013);
  - `busy` falls after `ss` rises.
- Start address 0xFFFF with 2 words → pulses at `paddr` 0xFFFF then 0x0000.
- `ss` rises after 20 bits of the second word → only 1 pulse; a following status frame returns byte 0 = 0x01.
- Status after a write of 1 word 0x01020304:
  - with `SPI_PROG_CRC_EN`: bytes 0x01, then the CRC-8 of 01 02 03 04, which is 0xE3;
  - without it: 0x01, 0x00.
- Frame with `PROGRAM`=0, then command 0xA5 with `PROGRAM`=1 → no pulses, `miso` stays 0.
- `aresetbar` asserted mid-word, then a new burst with start address 0x0004 and data 0x11111111 → pulse at (0x0004, 0x11111111); all outputs are 0 during reset.

Source files
------------

// File: rtl/spi_prog_loader.sv
// rtl/spi_prog_loader.sv - SPI mode-0 program loader driving MRAM write strobes (optional CRC: SPI_PROG_CRC_EN)
module spi_prog_loader #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              aresetbar,
    input  logic              PROGRAM,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic              pwe_pulse_q,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_STAT,
        S_IGNORE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_d;
    logic                   ss_d;

    state_t            state;
    logic [30:0]       shreg;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        wcount;
    logic [15:0]       tx_sr;
    logic [7:0]        crc_byte;

    logic        sclk_s, ss_s, mosi_s;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [31:0] rx_word;
    logic        cmd_wr_hit;

    // Synchronizers reset low so a held-low ss at reset release never looks like a frame start.
    always_ff @(posedge clk or negedge aresetbar) begin
        if (!aresetbar) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign rx_word   = {shreg, mosi_s};
    assign busy      = (state != S_IDLE);

    assign cmd_wr_hit = (state == S_CMD) && sclk_rise && (bit_cnt == 5'd7) &&
                        (rx_word[7:0] == 8'h02) && !ss_rise && PROGRAM;

    always_ff @(posedge clk or negedge aresetbar) begin
        if (!aresetbar) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            addr_cnt    <= '0;
            wcount      <= '0;
            tx_sr       <= '0;
            miso        <= 1'b0;
            pwe_pulse_q <= 1'b0;
            paddr       <= '0;
            pdata       <= '0;
        end else begin
            pwe_pulse_q <= 1'b0;
            if (pwe_pulse_q) begin
                addr_cnt <= addr_cnt + ADDR_ONE;
                wcount   <= wcount + 8'd1;
            end
            if (sclk_rise) begin
                shreg   <= rx_word[30:0];
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (state == S_IDLE) begin
                if (ss_fall) begin
                    bit_cnt <= '0;
                    miso    <= 1'b0;
                    state   <= PROGRAM ? S_CMD : S_IGNORE;
                end
            end else if (ss_rise) begin
                // ss rise wins over a same-cycle last-bit rise: the partial word is dropped.
                state <= S_IDLE;
                miso  <= 1'b0;
            end else if (!PROGRAM) begin
                state <= S_IGNORE;
                miso  <= 1'b0;
            end else begin
                case (state)
                    S_CMD: begin
                        if (sclk_rise && bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (cmd_wr_hit) begin
                                state  <= S_ADDR;
                                wcount <= '0;
                            end else if (rx_word[7:0] == 8'h05) begin
                                state <= S_STAT;
                                tx_sr <= {wcount, crc_byte};
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise && bit_cnt == 5'd15) begin
                            bit_cnt  <= '0;
                            addr_cnt <= ADDR_W'(rx_word[15:0]);
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (sclk_rise && bit_cnt == 5'd31) begin
                            pwe_pulse_q <= 1'b1;
                            paddr       <= addr_cnt;
                            pdata       <= rx_word;
                        end
                    end
                    S_STAT: begin
                        // Status bits launch on sclk falls so the host samples them on the next rise.
                        if (sclk_fall) begin
                            miso  <= tx_sr[15];
                            tx_sr <= {tx_sr[14:0], 1'b0};
                        end
                        if (sclk_rise && bit_cnt == 5'd15) begin
                            state <= S_IGNORE;
                            miso  <= 1'b0;
                        end
                    end
                    default: miso <= 1'b0;
                endcase
            end
        end
    end

`ifdef SPI_PROG_CRC_EN
    function automatic logic [7:0] crc8_word(input logic [7:0] c, input logic [31:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    logic [7:0] crc;

    // Folds each word in once it is strobed, so dropped partial words never reach the CRC.
    always_ff @(posedge clk or negedge aresetbar) begin
        if (!aresetbar) begin
            crc <= 8'h00;
        end else if (cmd_wr_hit) begin
            crc <= 8'h00;
        end else if (pwe_pulse_q) begin
            crc <= crc8_word(crc, pdata);
        end
    end

    assign crc_byte = crc;
`else
    assign crc_byte = 8'h00;
`endif

endmodule

// File: tb/tb_spi_prog_loader.sv
// tb/tb_spi_prog_loader.sv - scoreboard bench for spi_prog_loader
module tb_spi_prog_loader;

    localparam int HALF = 80;

    logic        clk       = 1'b0;
    logic        aresetbar = 1'b0;
    logic        PROGRAM   = 1'b1;
    logic        sclk      = 1'b0;
    logic        mosi      = 1'b0;
    logic        ss        = 1'b1;
    logic        miso;
    logic        pwe_pulse_q;
    logic [15:0] paddr;
    logic [31:0] pdata;
    logic        busy;

    spi_prog_loader dut (
        .clk        (clk),
        .aresetbar  (aresetbar),
        .PROGRAM    (PROGRAM),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .miso       (miso),
        .pwe_pulse_q(pwe_pulse_q),
        .paddr      (paddr),
        .pdata      (pdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_pulse = 1'b0;
    logic watch_miso = 1'b0;
    logic miso_seen  = 1'b0;
    logic [7:0] st0, st1, st2;
    logic [31:0] dummy;

`ifdef SPI_PROG_CRC_EN
    localparam logic [7:0] EXP_CRC = 8'hE3;
`else
    localparam logic [7:0] EXP_CRC = 8'h00;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pwe_pulse_q) begin
            check("pulse_width", 64'(prev_pulse), 64'(0));
            if (sb_q.size() == 0) begin
                check("extra_pulse", 64'(pwe_pulse_q), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("paddr", 64'(paddr), 64'(e.a));
                check("pdata", 64'(pdata), 64'(e.d));
            end
        end
        prev_pulse = pwe_pulse_q;
        if (watch_miso && miso) miso_seen = 1'b1;
    end

    task automatic xfer(input int n, input logic [31:0] v, output logic [31:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #HALF;
            sclk = 1'b1;
            r = {r[30:0], miso};
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        ss = 1'b1;
        #(4 * HALF);
    endtask

    task automatic write_burst(input logic [15:0] a, input int n, input logic [31:0] w0,
                               input logic [31:0] w1);
        logic [31:0] r;
        exp_t e;
        frame_begin();
        xfer(8, 32'h02, r);
        xfer(16, {16'h0, a}, r);
        for (int k = 0; k < n; k++) begin
            e.a = a + 16'(k);
            e.d = (k == 0) ? w0 : w1;
            sb_q.push_back(e);
            xfer(32, e.d, r);
        end
        check("busy_on", 64'(busy), 64'(1));
        frame_end();
        check("busy_off", 64'(busy), 64'(0));
        check("missing", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic status_read(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
        logic [31:0] r;
        frame_begin();
        xfer(8, 32'h05, r);
        xfer(8, 32'h0, r);
        b0 = r[7:0];
        xfer(8, 32'h0, r);
        b1 = r[7:0];
        xfer(8, 32'h0, r);
        b2 = r[7:0];
        frame_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pwe"}, 64'(pwe_pulse_q), 64'(0));
        check({tag, "_paddr"}, 64'(paddr), 64'(0));
        check({tag, "_pdata"}, 64'(pdata), 64'(0));
        check({tag, "_miso"}, 64'(miso), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        aresetbar = 1'b1;
        #(4 * HALF);

        write_burst(16'h0010, 2, 32'hDEADBEEF, 32'h00000013);
        write_burst(16'hFFFF, 2, 32'hA5A5A5A5, 32'h5A5A5A5A);

        begin
            exp_t e;
            frame_begin();
            xfer(8, 32'h02, dummy);
            xfer(16, 32'h0020, dummy);
            e.a = 16'h0020;
            e.d = 32'hCAFEF00D;
            sb_q.push_back(e);
            xfer(32, e.d, dummy);
            xfer(20, 32'h12345, dummy);
            frame_end();
            check("cut_missing", 64'(sb_q.size()), 64'(0));
            status_read(st0, st1, st2);
            check("cut_wcount", 64'(st0), 64'(8'h01));
        end

        write_burst(16'h0030, 1, 32'h01020304, 32'h0);
        status_read(st0, st1, st2);
        check("stat_wcount", 64'(st0), 64'(8'h01));
        check("stat_crc", 64'(st1), 64'(EXP_CRC));
        check("stat_tail", 64'(st2), 64'(8'h00));

        watch_miso = 1'b1;
        PROGRAM = 1'b0;
        frame_begin();
        xfer(8, 32'h02, dummy);
        xfer(16, 32'h0040, dummy);
        xfer(32, 32'h77777777, dummy);
        check("noprog_busy", 64'(busy), 64'(1));
        frame_end();
        PROGRAM = 1'b1;
        frame_begin();
        xfer(8, 32'hA5, dummy);
        xfer(32, 32'h02000505, dummy);
        xfer(32, 32'hFFFFFFFF, dummy);
        frame_end();
        watch_miso = 1'b0;
        check("miso_quiet", 64'(miso_seen), 64'(0));
        check("ignore_missing", 64'(sb_q.size()), 64'(0));

        frame_begin();
        xfer(8, 32'h02, dummy);
        xfer(16, 32'h0100, dummy);
        xfer(16, 32'hBEEF, dummy);
        aresetbar = 1'b0;
        #30;
        check_reset_outputs("midreset");
        ss = 1'b1;
        #(4 * HALF);
        aresetbar = 1'b1;
        #(4 * HALF);
        write_burst(16'h0004, 1, 32'h11111111, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
